bud_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the single budIf command interface (write_req/read_req/busy/len/address/wdata).
- Lets two independent sources (e.g. the button-driven UART text writer and a status poller) share one AXI master without colliding.
- Captures one command per grant, drives budIf for exactly one accepted transaction, then reports completion to the owning requester.

---
 rtl/bud_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_bud_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bud_arbiter.sv
// Two-requester round-robin arbiter that serialises commands onto the single
// budIf command port and reports completion back to the requester that owns it.
module bud_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 10,
  parameter int DATA_W  = 64,
  parameter int BUSY_TO = 15
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESET,

  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [LEN_W-1:0]  r0_len,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_done,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [LEN_W-1:0]  r1_len,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_done,
  output logic              r1_err,

  output logic              write_req,
  output logic              read_req,
  output logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  input  logic              busy
);

  localparam int CNT_W = $clog2(BUSY_TO + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TO);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t            state, state_d;
  logic              owner, owner_d;
  logic              last_grant, last_grant_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_inc;
  logic              write_req_d, read_req_d;
  logic [LEN_W-1:0]  len_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] wdata_d;
  logic [1:0]        ack, ack_d;
  logic [1:0]        done, done_d;
  logic              err, err_d;

  logic              grant_valid, grant_id;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (r0_req && r1_req) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant;
    end else if (r0_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (r1_req) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  always_comb begin
    sel_wr    = grant_id ? r1_wr    : r0_wr;
    sel_addr  = grant_id ? r1_addr  : r0_addr;
    sel_len   = grant_id ? r1_len   : r0_len;
    sel_wdata = grant_id ? r1_wdata : r0_wdata;
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Grants are held off while a done pulse is out, so a requester still
  // holding req on its completion cycle is only re-evaluated one cycle later.
  always_comb begin
    state_d      = state;
    owner_d      = owner;
    last_grant_d = last_grant;
    cnt_d        = cnt;
    write_req_d  = write_req;
    read_req_d   = read_req;
    len_d        = len;
    address_d    = address;
    wdata_d      = wdata;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 1'b0;

    case (state)
      IDLE: begin
        if (grant_valid && (done == 2'b00)) begin
          owner_d          = grant_id;
          last_grant_d     = grant_id;
          len_d            = sel_len;
          address_d        = sel_addr;
          wdata_d          = sel_wdata;
          ack_d[grant_id]  = 1'b1;
          if (sel_len == '0) begin
            done_d[grant_id] = 1'b1;
            err_d            = 1'b1;
          end else begin
            write_req_d = sel_wr;
            read_req_d  = ~sel_wr;
            state_d     = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (!busy) begin
          write_req_d = 1'b0;
          read_req_d  = 1'b0;
          cnt_d       = '0;
          state_d     = WAIT_BUSY;
        end
      end

      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            done_d[owner] = 1'b1;
            err_d         = 1'b1;
            state_d       = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!busy) begin
          done_d[owner] = 1'b1;
          state_d       = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      write_req  <= 1'b0;
      read_req   <= 1'b0;
      len        <= '0;
      address    <= '0;
      wdata      <= '0;
      ack        <= 2'b00;
      done       <= 2'b00;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
      write_req  <= write_req_d;
      read_req   <= read_req_d;
      len        <= len_d;
      address    <= address_d;
      wdata      <= wdata_d;
      ack        <= ack_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  assign r0_ack  = ack[0];
  assign r1_ack  = ack[1];
  assign r0_done = done[0];
  assign r1_done = done[1];
  assign r0_err  = done[0] & err;
  assign r1_err  = done[1] & err;

endmodule

// File: tb/tb_bud_arbiter.sv
// Bench for bud_arbiter: directed timing scenarios plus randomized traffic,
// checked by a per-requester scoreboard and a behavioural budIf responder.
module tb_bud_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 10;
  localparam int DATA_W  = 64;
  localparam int BUSY_TO = 15;

  logic              M_AXI_ACLK = 1'b0;
  logic              M_AXI_ARESET;
  logic              r0_req, r0_wr, r0_ack, r0_done, r0_err;
  logic [ADDR_W-1:0] r0_addr;
  logic [LEN_W-1:0]  r0_len;
  logic [DATA_W-1:0] r0_wdata;
  logic              r1_req, r1_wr, r1_ack, r1_done, r1_err;
  logic [ADDR_W-1:0] r1_addr;
  logic [LEN_W-1:0]  r1_len;
  logic [DATA_W-1:0] r1_wdata;
  logic              write_req, read_req, busy;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;

  bud_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .BUSY_TO(BUSY_TO)
  ) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_len(r0_len),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_len(r1_len),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_done(r1_done), .r1_err(r1_err),
    .write_req(write_req), .read_req(read_req), .len(len),
    .address(address), .wdata(wdata), .busy(busy)
  );

  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [9:0]  len;
    logic [63:0] wdata;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];
  int   exp_grant[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int owner = -1;
  int accept_cyc = 0;
  int wr_cycles = 0;
  int rd_cycles = 0;
  int dones = 0;

  int          bus_hold = 5;
  bit          bus_auto = 1'b1;
  bit          rand_hold = 1'b0;
  int          remain = 0;
  bit          prev_acc = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(posedge M_AXI_ACLK) cyc <= cyc + 1;

  // The responder never answers addresses ending in 2'b11, so those time out.
  function automatic logic exp_err(input cmd_t c);
    return (c.len == 10'd0) || (c.addr[1:0] == 2'b11);
  endfunction

  function automatic cmd_t mk(input logic wr, input logic [31:0] a,
                              input logic [9:0] l, input logic [63:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.len = l; c.wdata = d;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event missing or unexpected", name);
  endtask

  task automatic tick();
    @(posedge M_AXI_ACLK);
    #1;
  endtask

  task automatic applyStimulus(input int id, input cmd_t c);
    if (id == 0) begin
      q0.push_back(c);
      r0_wr = c.wr; r0_addr = c.addr; r0_len = c.len; r0_wdata = c.wdata;
      r0_req = 1'b1;
    end else begin
      q1.push_back(c);
      r1_wr = c.wr; r1_addr = c.addr; r1_len = c.len; r1_wdata = c.wdata;
      r1_req = 1'b1;
    end
  endtask

  task automatic dropReq(input int id);
    if (id == 0) r0_req = 1'b0;
    else r1_req = 1'b0;
  endtask

  task automatic waitAck(input int id);
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((id == 0 && r0_ack) || (id == 1 && r1_ack)) return;
    end
    failNow("ack_wait");
  endtask

  task automatic waitDone(input int id);
    for (int i = 0; i < 400; i++) begin
      tick();
      if ((id == 0 && r0_done) || (id == 1 && r1_done)) return;
    end
    failNow("done_wait");
  endtask

  task automatic holdStream(input int id, input int n, input cmd_t c);
    for (int k = 0; k < n; k++) begin
      applyStimulus(id, c);
      waitAck(id);
    end
    dropReq(id);
  endtask

  task automatic randStream(input int id, input int n);
    cmd_t c;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      c.wr    = 1'($urandom_range(0, 1));
      c.addr  = $urandom;
      c.len   = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      c.wdata = {$urandom, $urandom};
      applyStimulus(id, c);
      waitAck(id);
      dropReq(id);
    end
  endtask

  // budIf responder: busy rises the cycle after acceptance and stays high for a hold time.
  initial begin
    forever begin
      tick();
      if (!bus_auto || M_AXI_ARESET) begin
        remain   = 0;
        prev_acc = 1'b0;
      end else begin
        if (prev_acc && prev_addr[1:0] != 2'b11) begin
          busy   = 1'b1;
          remain = (rand_hold ? int'($urandom_range(1, 5)) : bus_hold) - 1;
        end else if (remain > 0) begin
          busy = 1'b1;
          remain--;
        end else begin
          busy = 1'b0;
        end
        prev_acc  = (write_req || read_req) && !busy;
        prev_addr = address;
      end
    end
  end

  task automatic onAck(input int id);
    int n;
    n = (id == 0) ? q0.size() : q1.size();
    checkOutput("ack_has_cmd", 64'(n > 0), 64'd1);
    owner = id;
    if (exp_grant.size() > 0) checkOutput("grant_order", 64'(id), 64'(exp_grant.pop_front()));
  endtask

  task automatic onDone(input int id, input logic e);
    cmd_t c;
    checkOutput("done_owner", 64'(id), 64'(owner));
    dones++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      failNow("done_no_cmd");
      return;
    end
    if (id == 0) c = q0.pop_front();
    else c = q1.pop_front();
    checkOutput("done_err", 64'(e), 64'(exp_err(c)));
  endtask

  task automatic onBus();
    cmd_t c;
    checkOutput("req_exclusive", 64'(write_req & read_req), 64'd0);
    if (write_req) wr_cycles++;
    if (read_req) rd_cycles++;
    if (owner == 0 && q0.size() > 0) c = q0[0];
    else if (owner == 1 && q1.size() > 0) c = q1[0];
    else begin
      failNow("bus_owner");
      return;
    end
    checkOutput("bus_wr", 64'(write_req), 64'(c.wr));
    checkOutput("bus_addr", 64'(address), 64'(c.addr));
    checkOutput("bus_len", 64'(len), 64'(c.len));
    checkOutput("bus_wdata", wdata, c.wdata);
    if (!busy) accept_cyc = cyc;
  endtask

  always @(negedge M_AXI_ACLK) begin
    if (!M_AXI_ARESET) begin
      if (r0_ack || r1_ack) checkOutput("ack_onehot", 64'(r0_ack & r1_ack), 64'd0);
      if (r0_ack) onAck(0);
      if (r1_ack) onAck(1);
      if (write_req || read_req) onBus();
      if (r0_done) onDone(0, r0_err);
      if (r1_done) onDone(1, r1_err);
      if (r0_err) checkOutput("err0_with_done", 64'(r0_done), 64'd1);
      if (r1_err) checkOutput("err1_with_done", 64'(r1_done), 64'd1);
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, w0, rd0, d0;
    cmd_t ca, cb;
    r0_req = 0; r0_wr = 0; r0_addr = '0; r0_len = '0; r0_wdata = '0;
    r1_req = 0; r1_wr = 0; r1_addr = '0; r1_len = '0; r1_wdata = '0;
    busy = 0;
    M_AXI_ARESET = 1'b1;

    $display("[TB] reset state");
    repeat (3) tick();
    checkOutput("rst_strobes", 64'({write_req, read_req, r0_ack, r0_done, r0_err,
                                    r1_ack, r1_done, r1_err}), 64'd0);
    checkOutput("rst_addr", 64'(address), 64'd0);
    checkOutput("rst_len", 64'(len), 64'd0);
    checkOutput("rst_wdata", wdata, 64'd0);
    M_AXI_ARESET = 1'b0;
    tick();

    $display("[TB] single write");
    bus_hold = 5;
    t0 = cyc; w0 = wr_cycles; rd0 = rd_cycles;
    applyStimulus(0, mk(1'b1, 32'h4060_0004, 10'd4, 64'h0000_0068_0000_0000));
    tick();
    checkOutput("sw_ack", 64'(r0_ack), 64'd1);
    checkOutput("sw_write_req", 64'(write_req), 64'd1);
    checkOutput("sw_read_req", 64'(read_req), 64'd0);
    dropReq(0);
    waitDone(0);
    checkOutput("sw_done_cycle", 64'(cyc - t0), 64'd8);
    checkOutput("sw_err", 64'(r0_err), 64'd0);
    checkOutput("sw_wr_cycles", 64'(wr_cycles - w0), 64'd1);
    checkOutput("sw_rd_cycles", 64'(rd_cycles - rd0), 64'd0);

    $display("[TB] zero length from r1");
    tick();
    w0 = wr_cycles; rd0 = rd_cycles;
    applyStimulus(1, mk(1'b0, 32'h4060_0010, 10'd0, 64'h1234));
    tick();
    checkOutput("l0_ack", 64'(r1_ack), 64'd1);
    checkOutput("l0_done", 64'(r1_done), 64'd1);
    checkOutput("l0_err", 64'(r1_err), 64'd1);
    dropReq(1);
    repeat (3) tick();
    checkOutput("l0_no_req", 64'((wr_cycles - w0) + (rd_cycles - rd0)), 64'd0);

    $display("[TB] simultaneous held requests");
    bus_hold = 2;
    for (int k = 0; k < 3; k++) begin
      exp_grant.push_back(0);
      exp_grant.push_back(1);
    end
    ca = mk(1'b1, 32'h4060_0004, 10'd4, 64'h0000_0068_0000_0000);
    cb = mk(1'b0, 32'h4060_0008, 10'd1, 64'h0);
    tick();
    fork
      holdStream(0, 3, ca);
      holdStream(1, 3, cb);
    join
    waitDone(1);
    checkOutput("tie_grants_left", 64'(exp_grant.size()), 64'd0);

    $display("[TB] busy high on issue");
    tick();
    bus_auto = 1'b0;
    busy = 1'b1;
    t0 = cyc; w0 = wr_cycles;
    applyStimulus(0, mk(1'b1, 32'h4060_0020, 10'd8, {$urandom, $urandom}));
    tick();
    checkOutput("bh_ack", 64'(r0_ack), 64'd1);
    dropReq(0);
    repeat (4) tick();
    busy = 1'b0;
    tick();
    busy = 1'b1;
    repeat (2) tick();
    busy = 1'b0;
    waitDone(0);
    checkOutput("bh_accept", 64'(accept_cyc - t0), 64'd5);
    checkOutput("bh_wr_cycles", 64'(wr_cycles - w0), 64'd5);
    checkOutput("bh_done_cycle", 64'(cyc - t0), 64'd9);
    bus_auto = 1'b1;

    $display("[TB] busy never rises");
    tick();
    applyStimulus(0, mk(1'b1, 32'h4060_0007, 10'd3, 64'hAB));
    waitAck(0);
    dropReq(0);
    waitDone(0);
    checkOutput("to_latency", 64'(cyc - accept_cyc), 64'(BUSY_TO + 1));
    checkOutput("to_err", 64'(r0_err), 64'd1);
    tick();
    applyStimulus(1, mk(1'b0, 32'h4060_0008, 10'd2, 64'h0));
    waitAck(1);
    dropReq(1);
    waitDone(1);
    checkOutput("to_next_err", 64'(r1_err), 64'd0);

    $display("[TB] reset during wait for done");
    bus_hold = 10;
    tick();
    d0 = dones;
    applyStimulus(0, mk(1'b1, 32'h4060_0004, 10'd4, 64'h55));
    waitAck(0);
    dropReq(0);
    repeat (3) tick();
    M_AXI_ARESET = 1'b1;
    bus_auto = 1'b0;
    busy = 1'b0;
    tick();
    checkOutput("mr_strobes", 64'({write_req, read_req, r0_ack, r0_done, r0_err,
                                   r1_ack, r1_done, r1_err}), 64'd0);
    checkOutput("mr_addr", 64'(address), 64'd0);
    checkOutput("mr_len", 64'(len), 64'd0);
    q0.delete();
    M_AXI_ARESET = 1'b0;
    repeat (12) tick();
    checkOutput("mr_no_done", 64'(dones - d0), 64'd0);
    bus_auto = 1'b1;
    bus_hold = 2;
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    fork
      holdStream(0, 1, ca);
      holdStream(1, 1, cb);
    join
    waitDone(1);
    checkOutput("mr_tie_grants_left", 64'(exp_grant.size()), 64'd0);

    $display("[TB] randomized traffic");
    rand_hold = 1'b1;
    tick();
    fork
      randStream(0, 20);
      randStream(1, 20);
    join
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick();
    end
    checkOutput("end_q0_empty", 64'(q0.size()), 64'd0);
    checkOutput("end_q1_empty", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
